// File: rtl/pop_lz_issue_ctrl_if.sv
// Issue, dispatch and A-register writeback signals of the
// pop count / leading-zero issue controller.
interface pop_lz_issue_ctrl_if;
    logic        i_issue_valid;
    logic [6:0]  i_instr;
    logic [2:0]  i_ai;
    logic [63:0] i_sj;
    logic        o_issue_ready;
    logic [63:0] o_unit_sj;
    logic [6:0]  o_unit_instr;
    logic [23:0] i_unit_result;
    logic        o_a_we;
    logic [2:0]  o_a_addr;
    logic [23:0] o_a_data;
    logic [7:0]  o_a_busy;
    logic        o_illegal;

    modport master (
        output i_issue_valid,
        output i_instr,
        output i_ai,
        output i_sj,
        output i_unit_result,
        input  o_issue_ready,
        input  o_unit_sj,
        input  o_unit_instr,
        input  o_a_we,
        input  o_a_addr,
        input  o_a_data,
        input  o_a_busy,
        input  o_illegal
    );

    modport slave (
        input  i_issue_valid,
        input  i_instr,
        input  i_ai,
        input  i_sj,
        input  i_unit_result,
        output o_issue_ready,
        output o_unit_sj,
        output o_unit_instr,
        output o_a_we,
        output o_a_addr,
        output o_a_data,
        output o_a_busy,
        output o_illegal
    );
endinterface

// File: rtl/pop_lz_issue_ctrl.sv
// Issue/writeback control for the 026 pop count and 027 leading-zero
// unit: return-slot reservation, fixed-latency capture, Ai scoreboard.
module pop_lz_issue_ctrl #(
    parameter int POP_LAT = 6,
    parameter int LZ_LAT  = 5,
    parameter int DRAIN   = 4
) (
    input logic               clk,
    input logic               rst,
    pop_lz_issue_ctrl_if.slave bus
);
    localparam logic [6:0] OP_POP = 7'b0010110;
    localparam logic [6:0] OP_LZ  = 7'b0010111;
    localparam int NSLOT = (POP_LAT > LZ_LAT) ? POP_LAT : LZ_LAT;
    localparam int DW    = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

    typedef struct packed {
        logic       valid;
        logic [2:0] ai;
    } slot_t;

    slot_t         slot   [1:NSLOT];
    slot_t         slot_n [1:NSLOT];
    logic [DW-1:0] drain_cnt;
    logic [7:0]    busy_n;
    logic          is_pop;
    logic          is_lz;
    logic          legal;
    logic          draining;
    logic          busy_hit;
    logic          ready;
    logic          accept;
    logic          issue;

    always_comb begin
        is_pop   = (bus.i_instr == OP_POP);
        is_lz    = (bus.i_instr == OP_LZ);
        legal    = is_pop | is_lz;
        draining = (drain_cnt != '0);
        busy_hit = bus.o_a_busy[bus.i_ai];
        ready    = 1'b0;
        // Slot LAT shifts into LAT-1 this cycle; that is where a new entry lands.
        unique case (1'b1)
            is_pop:  ready = !draining && !busy_hit
                             && !slot[POP_LAT].valid;
            is_lz:   ready = !draining && !busy_hit
                             && !slot[LZ_LAT].valid;
            default: ready = !draining;
        endcase
        accept = bus.i_issue_valid & ready;
        issue  = accept & legal;
    end

    assign bus.o_issue_ready = ready;

    always_comb begin
        for (int k = 1; k < NSLOT; k++) begin
            slot_n[k] = slot[k+1];
        end
        slot_n[NSLOT] = '0;
        if (issue && is_pop) begin
            slot_n[POP_LAT-1].valid = 1'b1;
            slot_n[POP_LAT-1].ai    = bus.i_ai;
        end
        if (issue && is_lz) begin
            slot_n[LZ_LAT-1].valid = 1'b1;
            slot_n[LZ_LAT-1].ai    = bus.i_ai;
        end
    end

    // Set after clear so a same-cycle collision leaves the bit busy.
    always_comb begin
        busy_n = bus.o_a_busy;
        if (bus.o_a_we) begin
            busy_n[bus.o_a_addr] = 1'b0;
        end
        if (issue) begin
            busy_n[bus.i_ai] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= NSLOT; k++) begin
                slot[k] <= '0;
            end
            drain_cnt        <= DW'(DRAIN);
            bus.o_a_busy     <= '0;
            bus.o_a_we       <= 1'b0;
            bus.o_a_addr     <= '0;
            bus.o_a_data     <= '0;
            bus.o_unit_instr <= '0;
            bus.o_unit_sj    <= '0;
            bus.o_illegal    <= 1'b0;
        end else begin
            for (int k = 1; k <= NSLOT; k++) begin
                slot[k] <= slot_n[k];
            end
            if (draining) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            bus.o_a_busy <= busy_n;
            bus.o_a_we   <= slot[1].valid;
            if (slot[1].valid) begin
                bus.o_a_addr <= slot[1].ai;
                bus.o_a_data <= bus.i_unit_result;
            end
            bus.o_unit_instr <= issue ? bus.i_instr : 7'b0;
            if (issue) begin
                bus.o_unit_sj <= bus.i_sj;
            end
            bus.o_illegal <= accept & ~legal;
        end
    end
endmodule

// File: tb/tb_pop_lz_issue_ctrl.sv
// Bench for pop_lz_issue_ctrl: behavioural pop/lz unit, write
// scoreboard keyed by due cycle, vector table plus corner sequences.
module tb_pop_lz_issue_ctrl;
    localparam logic [6:0] POP = 7'b0010110;
    localparam logic [6:0] LZ  = 7'b0010111;
    localparam logic [6:0] BAD = 7'b0010101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pop_lz_issue_ctrl_if bus();

    pop_lz_issue_ctrl #(
        .POP_LAT(6),
        .LZ_LAT (5),
        .DRAIN  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endfunction

    function automatic logic [23:0] popc(logic [63:0] x);
        logic [23:0] n = '0;
        for (int i = 0; i < 64; i++) n = n + 24'(x[i]);
        return n;
    endfunction

    function automatic logic [23:0] lzc(logic [63:0] x);
        logic [23:0] n = '0;
        bit seen = 0;
        for (int i = 63; i >= 0; i--) begin
            if (x[i]) seen = 1;
            if (!seen) n = n + 24'd1;
        end
        return n;
    endfunction

    // Unit model: pop result visible 4 cycles after dispatch, lz 3.
    typedef struct packed {
        logic        v;
        logic [23:0] d;
    } res_t;
    res_t rline [0:3] = '{default: '0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) rline[k] <= rline[k+1];
        rline[3] <= '0;
        if (bus.o_unit_instr == POP)
            rline[3] <= '{1'b1, popc(bus.o_unit_sj)};
        else if (bus.o_unit_instr == LZ)
            rline[2] <= '{1'b1, lzc(bus.o_unit_sj)};
    end

    assign bus.i_unit_result = rline[0].v ? rline[0].d : 24'h0;

    typedef struct {
        int          due;
        logic [2:0]  ai;
        logic [23:0] d;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        int idx;
        if (rst && bus.o_a_we) begin
            idx = -1;
            foreach (sb[i]) if (sb[i].due == cyc) idx = i;
            if (idx < 0) begin
                n_chk++;
                $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none required",
                         bus.o_a_addr, bus.o_a_data, cyc);
            end else begin
                chk("wr_addr", 64'(bus.o_a_addr), 64'(sb[idx].ai));
                chk("wr_data", 64'(bus.o_a_data), 64'(sb[idx].d));
                sb.delete(idx);
            end
        end
    end

    task automatic at_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] ai,
                         input logic [63:0] sj, input logic [23:0] d,
                         output int acc);
        bus.i_issue_valid = 1'b1;
        bus.i_instr       = op;
        bus.i_ai          = ai;
        bus.i_sj          = sj;
        acc = -1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (bus.o_issue_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_chk++;
            $display("FAIL issue_timeout: op %0h ai %0d never accepted, required within 30 cycles",
                     op, ai);
        end else if (op == POP || op == LZ) begin
            sb.push_back('{due: acc + ((op == POP) ? 6 : 5), ai: ai, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_issue_valid = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  ai;
        logic [63:0] sj;
        logic [23:0] d;
    } vec_t;
    vec_t vt [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, b, c, lat, t0;
        vt[0] = '{POP, 3'd3, 64'hFFFF_0000_0000_0001, 24'h000011};
        vt[1] = '{LZ,  3'd5, 64'h0000_0000_0080_0000, 24'h000028};
        vt[2] = '{LZ,  3'd5, 64'h0, 24'h000040};
        vt[3] = '{POP, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 24'h000040};
        vt[4] = '{POP, 3'd7, 64'h0, 24'h000000};
        vt[5] = '{LZ,  3'd1, 64'h1, 24'h00003F};
        vt[6] = '{LZ,  3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 24'h000000};
        vt[7] = '{POP, 3'd4, 64'h8000_0000_0000_0000, 24'h000001};

        bus.i_issue_valid = 1'b0;
        bus.i_instr       = 7'b0;
        bus.i_ai          = 3'd0;
        bus.i_sj          = 64'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",     64'(bus.o_a_we), 64'd0);
        chk("rst_addr",   64'(bus.o_a_addr), 64'd0);
        chk("rst_data",   64'(bus.o_a_data), 64'd0);
        chk("rst_busy",   64'(bus.o_a_busy), 64'd0);
        chk("rst_uinstr", 64'(bus.o_unit_instr), 64'd0);
        chk("rst_usj",    bus.o_unit_sj, 64'd0);
        chk("rst_ill",    64'(bus.o_illegal), 64'd0);
        chk("rst_ready",  64'(bus.o_issue_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_instr = POP;
        t0 = cyc;
        at_neg(t0);
        chk("drain_first", 64'(bus.o_issue_ready), 64'd0);
        at_neg(t0 + 3);
        chk("drain_last", 64'(bus.o_issue_ready), 64'd0);
        at_neg(t0 + 4);
        chk("drain_done", 64'(bus.o_issue_ready), 64'd1);
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].ai, vt[i].sj, vt[i].d, a);
            idle();
            lat = (vt[i].op == POP) ? 6 : 5;
            at_neg(a + 1);
            chk("busy_set", 64'(bus.o_a_busy[vt[i].ai]), 64'd1);
            chk("disp_op",  64'(bus.o_unit_instr), 64'(vt[i].op));
            chk("disp_sj",  bus.o_unit_sj, vt[i].sj);
            at_neg(a + 2);
            chk("disp_idle", 64'(bus.o_unit_instr), 64'd0);
            at_neg(a + lat);
            chk("we_at_lat", 64'(bus.o_a_we), 64'd1);
            chk("busy_hold", 64'(bus.o_a_busy[vt[i].ai]), 64'd1);
            at_neg(a + lat + 1);
            chk("busy_clr", 64'(bus.o_a_busy), 64'd0);
            chk("we_pulse", 64'(bus.o_a_we), 64'd0);
            @(posedge clk);
            #1;
        end

        issue(POP, 3'd1, 64'hF, 24'h4, a);
        issue(LZ,  3'd2, 64'h1, 24'h3F, b);
        idle();
        chk("pop_lz_stall", 64'(b), 64'(a + 2));
        at_neg(a + 8);
        chk("pop_lz_busy", 64'(bus.o_a_busy), 64'd0);
        @(posedge clk);
        #1;

        issue(LZ,  3'd2, 64'h0000_0001_0000_0000, 24'h1F, a);
        issue(POP, 3'd1, 64'h3, 24'h2, b);
        idle();
        chk("lz_pop_nostall", 64'(b), 64'(a + 1));
        at_neg(a + 8);
        chk("lz_pop_busy", 64'(bus.o_a_busy), 64'd0);
        @(posedge clk);
        #1;

        issue(POP, 3'd6, 64'hFF, 24'h8, a);
        issue(BAD, 3'd6, 64'h1234, 24'h0, b);
        idle();
        chk("ill_accept", 64'(b), 64'(a + 1));
        at_neg(b + 1);
        chk("ill_pulse",  64'(bus.o_illegal), 64'd1);
        chk("ill_nodisp", 64'(bus.o_unit_instr), 64'd0);
        chk("ill_nobusy", 64'(bus.o_a_busy), 64'h40);
        at_neg(b + 2);
        chk("ill_once", 64'(bus.o_illegal), 64'd0);
        @(posedge clk);
        #1;
        issue(LZ, 3'd6, 64'h1, 24'h3F, c);
        idle();
        chk("busy_stall", 64'(c), 64'(a + 7));
        at_neg(c + 6);
        chk("busy_stall_clr", 64'(bus.o_a_busy), 64'd0);
        @(posedge clk);
        #1;

        issue(POP, 3'd3, 64'hAAAA, 24'h8, a);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_instr = LZ;
        bus.i_ai    = 3'd0;
        at_neg(a + 3);
        chk("mid_busy",   64'(bus.o_a_busy), 64'd0);
        chk("mid_we",     64'(bus.o_a_we), 64'd0);
        chk("mid_addr",   64'(bus.o_a_addr), 64'd0);
        chk("mid_data",   64'(bus.o_a_data), 64'd0);
        chk("mid_usj",    bus.o_unit_sj, 64'd0);
        chk("mid_ready0", 64'(bus.o_issue_ready), 64'd0);
        at_neg(a + 6);
        chk("mid_ready3", 64'(bus.o_issue_ready), 64'd0);
        at_neg(a + 7);
        chk("mid_ready4", 64'(bus.o_issue_ready), 64'd1);
        at_neg(a + 14);
        chk("mid_busy_end", 64'(bus.o_a_busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
